apb_ucpd_tx_sched: RTL and testbench
====================================

Name: apb_ucpd_tx_sched

Overview:
Transmit scheduler in front of the UCPD PD main FSM, in the ic_clk domain.
- Latches software TXSEND and TXHRST commands.
- Gives hard reset priority over messages.
- Enforces the inter-frame gap and receive-collision avoidance.
- Drives the FSM request levels (transmit_en, tx_hrst, mode flags).
- Reports sent, discard and error events back to the status and interrupt logic.

Parameters:
IFRGAP_CYC, 400, inter-frame gap in ic_clk cycles (25 us at 16 MHz); legal range 1..4095.
LAUNCH_TO, 1023, maximum ic_clk cycles from request assertion to bmc_en=1 before the job is aborted.

Ports:
ic_clk  in  1  UCPD kernel clock (HSI16)
ic_rst  in  1  asynchronous reset, active-high
ucpden  in  1  block enable; low synchronously clears all state, pends and outputs
txsend  in  1  single-cycle pulse: software message send command
txhrst  in  1  single-cycle pulse: software hard-reset command
tx_mode  in  2  captured with txsend: 00 SOP message, 01 cable reset, 10 BIST, 11 treated as 00
rx_idle  in  1  PD receive FSM is in RX_IDLE
bmc_en  in  1  PD transmit FSM is active
transmit_en  out  1  message/cable/BIST request level to the FSM
tx_hrst  out  1  hard-reset request level to the FSM
tx_hrst_flag  out  1  current job is a hard reset
tx_crst_flag  out  1  current job is a cable reset
bist_req  out  1  current job is BIST
msg_sent  out  1  pulse: message, cable-reset or BIST job completed
hrst_sent  out  1  pulse: hard-reset job completed
msg_disc  out  1  pulse: message job discarded or aborted
hrst_disc  out  1  pulse: hard-reset command dropped as a duplicate
tx_err  out  1  pulse: launch timeout
sched_busy  out  1  state is not IDLE, or a command is pending

Behaviour:
- Reset and ucpden=0:
  - State goes to IDLE; msg_pend, hrst_pend, gap_cnt (12 bit) and launch_cnt (10 bit) clear.
  - All outputs are 0.
- Command capture:
  - txsend sets msg_pend and latches tx_mode. If msg_pend is already set or a message job is active, the pulse is ignored and msg_disc pulses.
  - txhrst sets hrst_pend. If hrst_pend is already set or a hard-reset job is active, hrst_disc pulses.
  - txsend and txhrst in the same cycle: both are captured.
- IDLE:
  - hrst_pend=1: job=HRST, clear hrst_pend; if msg_pend is also set, clear it and pulse msg_disc. Go to GAP.
  - Else msg_pend=1 and rx_idle=1: job=MSG, clear msg_pend, go to GAP.
  - Else msg_pend=1 and rx_idle=0: clear msg_pend, pulse msg_disc, stay in IDLE.
- GAP:
  - gap_cnt increments each cycle while rx_idle=1 and bmc_en=0; it clears to 0 whenever either condition fails.
  - When gap_cnt==IFRGAP_CYC-1, go to ARM and clear gap_cnt.
  - MSG job and rx_idle falls: pulse msg_disc, return to IDLE.
  - HRST job and rx_idle falls: keep waiting; the counter restarts.
  - hrst_pend set while a MSG job is in GAP: pulse msg_disc, switch job to HRST, clear hrst_pend, restart gap_cnt.
- ARM:
  - Drive request outputs, registered and valid from the first ARM cycle:
    - HRST job: tx_hrst=1, tx_hrst_flag=1.
    - MSG job: transmit_en=1; tx_crst_flag=1 if mode 01; bist_req=1 if mode 10.
  - launch_cnt increments each cycle. bmc_en=1 goes to ACTIVE.
  - launch_cnt==LAUNCH_TO-1 with bmc_en=0: pulse tx_err, drop all requests, go to IDLE. The job is lost; no msg_disc.
- ACTIVE:
  - Outputs are held.
  - hrst_pend set during a MSG job: assert tx_hrst in addition, so the FSM truncates to EOP. On completion pulse msg_disc (not msg_sent), set job=HRST, clear hrst_pend, go to GAP.
  - Normal completion on the bmc_en 1->0 edge, detected with one registered copy of bmc_en:
    - All requests drop in the same cycle the edge is seen.
    - msg_sent or hrst_sent pulses one cycle later.
    - State goes to IDLE, and the next job must again pass GAP.
- Pulses: every event output is exactly one cycle wide and registered.
- Simultaneous pulse events: at most one of msg_disc / msg_sent in any cycle. If two message-disc causes coincide, a single pulse is emitted.
- ucpden falling mid-job: immediate return to IDLE. Nothing is reported.

Test Plan:
1. IFRGAP_CYC=400, rx_idle=1, txsend with mode 00 -> transmit_en rises exactly 401 cycles after the pulse. Drive bmc_en high for 50 cycles, then low -> transmit_en falls, msg_sent pulses 1 cycle later.
2. rx_idle=0, then txsend -> msg_disc pulses 1 cycle later, transmit_en stays 0, sched_busy returns to 0.
3. Message job in ACTIVE, txhrst pulse -> tx_hrst=1 alongside transmit_en. After bmc_en falls: msg_disc pulses, then after 400 idle cycles tx_hrst/tx_hrst_flag assert. After that second bmc_en pulse, hrst_sent pulses.
4. HRST job in GAP, rx_idle toggles low at gap_cnt=200 -> no discard; tx_hrst asserts 400 cycles after rx_idle returns high.
5. ARM with bmc_en held 0, LAUNCH_TO=1023 -> tx_err pulses after 1023 ARM cycles, all requests drop to 0.
6. Assert ic_rst mid-ACTIVE, and separately deassert ucpden mid-GAP -> all outputs 0 immediately/next cycle, no sent or disc pulse, fresh txsend works normally.

Source files
------------

// File: rtl/apb_ucpd_tx_sched.sv
// UCPD transmit scheduler: latches TXSEND/TXHRST, enforces the inter-frame gap and
// receive-collision rules, drives PD FSM request levels and reports job outcomes.
//
// state  | meaning
// IDLE   | no job; a pending hard reset wins over a pending message
// GAP    | counting quiet cycles (rx_idle=1, bmc_en=0) before launch
// ARM    | request levels driven, waiting for the PD FSM to raise bmc_en
// ACTIVE | PD FSM transmitting; job ends on the bmc_en falling edge
module apb_ucpd_tx_sched #(
  parameter int unsigned IFRGAP_CYC = 400,
  parameter int unsigned LAUNCH_TO  = 1023
) (
  input  logic       ic_clk,
  input  logic       ic_rst,
  input  logic       ucpden,
  input  logic       txsend,
  input  logic       txhrst,
  input  logic [1:0] tx_mode,
  input  logic       rx_idle,
  input  logic       bmc_en,
  output logic       transmit_en,
  output logic       tx_hrst,
  output logic       tx_hrst_flag,
  output logic       tx_crst_flag,
  output logic       bist_req,
  output logic       msg_sent,
  output logic       hrst_sent,
  output logic       msg_disc,
  output logic       hrst_disc,
  output logic       tx_err,
  output logic       sched_busy
);

  typedef enum logic [1:0] {S_IDLE, S_GAP, S_ARM, S_ACTIVE} state_t;

  localparam logic        JOB_MSG     = 1'b0;
  localparam logic        JOB_HRST    = 1'b1;
  localparam logic [11:0] GAP_LAST    = 12'(IFRGAP_CYC - 1);
  localparam logic [9:0]  LAUNCH_LAST = 10'(LAUNCH_TO - 1);

  state_t      state_q, state_d;
  logic        job_q, job_d;
  logic [1:0]  mode_q, mode_d;
  logic        msg_pend_q, msg_pend_d;
  logic        hrst_pend_q, hrst_pend_d;
  logic [11:0] gap_cnt_q, gap_cnt_d;
  logic [9:0]  launch_cnt_q, launch_cnt_d;
  logic        bmc_en_q;
  logic        fin_msg_q, fin_hrst_q, fin_trunc_q;
  logic        fin_msg_d, fin_hrst_d, fin_trunc_d;
  logic        msg_dup, hrst_dup, msg_take, hrst_take, disc_now, err_now;
  logic        te_d, hrst_req_d, hrst_flag_d, crst_flag_d, bist_d;
  logic        job_busy;

  assign job_busy   = (state_q != S_IDLE);
  assign sched_busy = job_busy | msg_pend_q | hrst_pend_q;

  always_comb begin
    state_d      = state_q;
    job_d        = job_q;
    gap_cnt_d    = '0;
    launch_cnt_d = '0;
    msg_take     = 1'b0;
    hrst_take    = 1'b0;
    disc_now     = 1'b0;
    err_now      = 1'b0;
    fin_msg_d    = 1'b0;
    fin_hrst_d   = 1'b0;
    fin_trunc_d  = 1'b0;
    msg_dup      = txsend & (msg_pend_q  | (job_busy & (job_q == JOB_MSG)));
    hrst_dup     = txhrst & (hrst_pend_q | (job_busy & (job_q == JOB_HRST)));

    case (state_q)
      S_IDLE: begin
        if (hrst_pend_q) begin
          job_d     = JOB_HRST;
          hrst_take = 1'b1;
          state_d   = S_GAP;
          if (msg_pend_q) begin
            msg_take = 1'b1;
            disc_now = 1'b1;
          end
        end else if (msg_pend_q) begin
          msg_take = 1'b1;
          if (rx_idle) begin
            job_d   = JOB_MSG;
            state_d = S_GAP;
          end else begin
            disc_now = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (job_q == JOB_MSG && hrst_pend_q) begin
          disc_now  = 1'b1;
          job_d     = JOB_HRST;
          hrst_take = 1'b1;
        end else if (job_q == JOB_MSG && !rx_idle) begin
          disc_now = 1'b1;
          state_d  = S_IDLE;
        end else if (rx_idle && !bmc_en) begin
          if (gap_cnt_q == GAP_LAST) state_d = S_ARM;
          else                       gap_cnt_d = gap_cnt_q + 12'd1;
        end
      end
      S_ARM: begin
        if (bmc_en) begin
          state_d = S_ACTIVE;
        end else if (launch_cnt_q == LAUNCH_LAST) begin
          err_now = 1'b1;
          state_d = S_IDLE;
        end else begin
          launch_cnt_d = launch_cnt_q + 10'd1;
        end
      end
      S_ACTIVE: begin
        if (bmc_en_q && !bmc_en) begin
          // A hard reset that arrived mid-message truncated it; run the reset next.
          if (job_q == JOB_MSG && hrst_pend_q) begin
            fin_trunc_d = 1'b1;
            job_d       = JOB_HRST;
            hrst_take   = 1'b1;
            state_d     = S_GAP;
          end else begin
            fin_msg_d  = (job_q == JOB_MSG);
            fin_hrst_d = (job_q == JOB_HRST);
            state_d    = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    disc_now    = disc_now | msg_dup;
    msg_pend_d  = (msg_pend_q & ~msg_take) | (txsend & ~msg_dup);
    hrst_pend_d = (hrst_pend_q & ~hrst_take) | (txhrst & ~hrst_dup);
    mode_d      = (txsend & ~msg_dup) ? tx_mode : mode_q;
  end

  always_comb begin
    te_d        = 1'b0;
    hrst_req_d  = 1'b0;
    hrst_flag_d = 1'b0;
    crst_flag_d = 1'b0;
    bist_d      = 1'b0;
    if (state_d == S_ARM || state_d == S_ACTIVE) begin
      if (job_d == JOB_HRST) begin
        hrst_req_d  = 1'b1;
        hrst_flag_d = 1'b1;
      end else begin
        te_d        = 1'b1;
        crst_flag_d = (mode_q == 2'b01);
        bist_d      = (mode_q == 2'b10);
        hrst_req_d  = (state_d == S_ACTIVE) & hrst_pend_d;
      end
    end
  end

  always_ff @(posedge ic_clk or posedge ic_rst) begin
    if (ic_rst) begin
      state_q      <= S_IDLE;
      job_q        <= JOB_MSG;
      mode_q       <= 2'b00;
      msg_pend_q   <= 1'b0;
      hrst_pend_q  <= 1'b0;
      gap_cnt_q    <= '0;
      launch_cnt_q <= '0;
      bmc_en_q     <= 1'b0;
      fin_msg_q    <= 1'b0;
      fin_hrst_q   <= 1'b0;
      fin_trunc_q  <= 1'b0;
      transmit_en  <= 1'b0;
      tx_hrst      <= 1'b0;
      tx_hrst_flag <= 1'b0;
      tx_crst_flag <= 1'b0;
      bist_req     <= 1'b0;
      msg_sent     <= 1'b0;
      hrst_sent    <= 1'b0;
      msg_disc     <= 1'b0;
      hrst_disc    <= 1'b0;
      tx_err       <= 1'b0;
    end else if (!ucpden) begin
      state_q      <= S_IDLE;
      job_q        <= JOB_MSG;
      mode_q       <= 2'b00;
      msg_pend_q   <= 1'b0;
      hrst_pend_q  <= 1'b0;
      gap_cnt_q    <= '0;
      launch_cnt_q <= '0;
      bmc_en_q     <= 1'b0;
      fin_msg_q    <= 1'b0;
      fin_hrst_q   <= 1'b0;
      fin_trunc_q  <= 1'b0;
      transmit_en  <= 1'b0;
      tx_hrst      <= 1'b0;
      tx_hrst_flag <= 1'b0;
      tx_crst_flag <= 1'b0;
      bist_req     <= 1'b0;
      msg_sent     <= 1'b0;
      hrst_sent    <= 1'b0;
      msg_disc     <= 1'b0;
      hrst_disc    <= 1'b0;
      tx_err       <= 1'b0;
    end else begin
      state_q      <= state_d;
      job_q        <= job_d;
      mode_q       <= mode_d;
      msg_pend_q   <= msg_pend_d;
      hrst_pend_q  <= hrst_pend_d;
      gap_cnt_q    <= gap_cnt_d;
      launch_cnt_q <= launch_cnt_d;
      bmc_en_q     <= bmc_en;
      fin_msg_q    <= fin_msg_d;
      fin_hrst_q   <= fin_hrst_d;
      fin_trunc_q  <= fin_trunc_d;
      transmit_en  <= te_d;
      tx_hrst      <= hrst_req_d;
      tx_hrst_flag <= hrst_flag_d;
      tx_crst_flag <= crst_flag_d;
      bist_req     <= bist_d;
      // Completion events land one cycle after the requests drop.
      msg_sent     <= fin_msg_q;
      hrst_sent    <= fin_hrst_q;
      msg_disc     <= (disc_now | fin_trunc_q) & ~fin_msg_q;
      hrst_disc    <= hrst_dup;
      tx_err       <= err_now;
    end
  end

endmodule

// File: tb/tb_apb_ucpd_tx_sched.sv
// Directed bench for apb_ucpd_tx_sched with hand-computed cycle counts.
module tb_apb_ucpd_tx_sched;

  logic       ic_clk = 1'b0;
  logic       ic_rst, ucpden, txsend, txhrst, rx_idle, bmc_en;
  logic [1:0] tx_mode;
  logic       transmit_en, tx_hrst, tx_hrst_flag, tx_crst_flag, bist_req;
  logic       msg_sent, hrst_sent, msg_disc, hrst_disc, tx_err, sched_busy;
  logic [10:0] outs;
  int n_cmp = 0;
  int n_bad = 0;

  apb_ucpd_tx_sched #(.IFRGAP_CYC(400), .LAUNCH_TO(1023)) dut (
    .ic_clk(ic_clk), .ic_rst(ic_rst), .ucpden(ucpden), .txsend(txsend),
    .txhrst(txhrst), .tx_mode(tx_mode), .rx_idle(rx_idle), .bmc_en(bmc_en),
    .transmit_en(transmit_en), .tx_hrst(tx_hrst), .tx_hrst_flag(tx_hrst_flag),
    .tx_crst_flag(tx_crst_flag), .bist_req(bist_req), .msg_sent(msg_sent),
    .hrst_sent(hrst_sent), .msg_disc(msg_disc), .hrst_disc(hrst_disc),
    .tx_err(tx_err), .sched_busy(sched_busy)
  );

  assign outs = {transmit_en, tx_hrst, tx_hrst_flag, tx_crst_flag, bist_req,
                 msg_sent, hrst_sent, msg_disc, hrst_disc, tx_err, sched_busy};

  always #5 ic_clk = ~ic_clk;

  task automatic tick();
    @(posedge ic_clk);
    #1;
  endtask

  task automatic pulse_send(input logic [1:0] m);
    tx_mode = m;
    txsend  = 1'b1;
    tick();
    txsend  = 1'b0;
  endtask

  task automatic pulse_hrst();
    txhrst = 1'b1;
    tick();
    txhrst = 1'b0;
  endtask

  task automatic wait_te(output int c);
    c = 0;
    while (transmit_en !== 1'b1 && c < 2000) begin
      tick();
      c++;
    end
  endtask

  task automatic wait_hrst(output int c);
    c = 0;
    while (tx_hrst !== 1'b1 && c < 2000) begin
      tick();
      c++;
    end
  endtask

  task automatic complete_job();
    bmc_en = 1'b1;
    repeat (2) tick();
    bmc_en = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_reset();
    ic_rst = 1'b1; ucpden = 1'b1; txsend = 1'b0; txhrst = 1'b0;
    tx_mode = 2'b00; rx_idle = 1'b1; bmc_en = 1'b0;
    repeat (3) tick();
    n_cmp++; if (outs !== 11'b0) begin n_bad++; $display("FAIL reset_outs got=%b exp=0", outs); end
    ic_rst = 1'b0;
    tick();
    n_cmp++; if (outs !== 11'b0) begin n_bad++; $display("FAIL post_reset_outs got=%b exp=0", outs); end
  endtask

  task automatic test_msg_basic();
    int c;
    pulse_send(2'b00);
    n_cmp++; if (sched_busy !== 1'b1) begin n_bad++; $display("FAIL busy_after_send got=%b exp=1", sched_busy); end
    wait_te(c);
    n_cmp++; if (c !== 401) begin n_bad++; $display("FAIL msg_gap_latency got=%0d exp=401", c); end
    n_cmp++; if ({tx_hrst, tx_hrst_flag, tx_crst_flag, bist_req} !== 4'b0) begin
      n_bad++; $display("FAIL msg_flags got=%b exp=0000", {tx_hrst, tx_hrst_flag, tx_crst_flag, bist_req}); end
    bmc_en = 1'b1;
    repeat (50) tick();
    n_cmp++; if (transmit_en !== 1'b1) begin n_bad++; $display("FAIL msg_held got=%b exp=1", transmit_en); end
    bmc_en = 1'b0;
    tick();
    n_cmp++; if ({transmit_en, msg_sent} !== 2'b00) begin n_bad++; $display("FAIL msg_drop got=%b exp=00", {transmit_en, msg_sent}); end
    tick();
    n_cmp++; if ({msg_sent, msg_disc, sched_busy} !== 3'b100) begin
      n_bad++; $display("FAIL msg_sent_pulse got=%b exp=100", {msg_sent, msg_disc, sched_busy}); end
    tick();
    n_cmp++; if (msg_sent !== 1'b0) begin n_bad++; $display("FAIL msg_sent_width got=%b exp=0", msg_sent); end
  endtask

  task automatic test_rx_busy();
    rx_idle = 1'b0;
    pulse_send(2'b00);
    n_cmp++; if ({msg_disc, sched_busy} !== 2'b01) begin n_bad++; $display("FAIL rxbusy_pend got=%b exp=01", {msg_disc, sched_busy}); end
    tick();
    n_cmp++; if ({msg_disc, transmit_en, sched_busy} !== 3'b100) begin
      n_bad++; $display("FAIL rxbusy_disc got=%b exp=100", {msg_disc, transmit_en, sched_busy}); end
    tick();
    n_cmp++; if (msg_disc !== 1'b0) begin n_bad++; $display("FAIL rxbusy_disc_width got=%b exp=0", msg_disc); end
    rx_idle = 1'b1;
    tick();
  endtask

  task automatic test_truncate();
    int c;
    pulse_send(2'b01);
    wait_te(c);
    n_cmp++; if (c !== 401) begin n_bad++; $display("FAIL crst_latency got=%0d exp=401", c); end
    n_cmp++; if ({transmit_en, tx_crst_flag, bist_req} !== 3'b110) begin
      n_bad++; $display("FAIL crst_flags got=%b exp=110", {transmit_en, tx_crst_flag, bist_req}); end
    bmc_en = 1'b1;
    repeat (3) tick();
    pulse_send(2'b00);
    n_cmp++; if (msg_disc !== 1'b1) begin n_bad++; $display("FAIL dup_send_disc got=%b exp=1", msg_disc); end
    tick();
    n_cmp++; if (msg_disc !== 1'b0) begin n_bad++; $display("FAIL dup_send_width got=%b exp=0", msg_disc); end
    pulse_hrst();
    tick();
    n_cmp++; if ({transmit_en, tx_hrst, tx_hrst_flag, hrst_disc} !== 4'b1100) begin
      n_bad++; $display("FAIL trunc_req got=%b exp=1100", {transmit_en, tx_hrst, tx_hrst_flag, hrst_disc}); end
    repeat (5) tick();
    bmc_en = 1'b0;
    tick();
    n_cmp++; if ({transmit_en, tx_hrst, tx_crst_flag, msg_disc} !== 4'b0) begin
      n_bad++; $display("FAIL trunc_drop got=%b exp=0000", {transmit_en, tx_hrst, tx_crst_flag, msg_disc}); end
    tick();
    n_cmp++; if ({msg_disc, msg_sent} !== 2'b10) begin n_bad++; $display("FAIL trunc_disc got=%b exp=10", {msg_disc, msg_sent}); end
    wait_hrst(c);
    n_cmp++; if (c + 1 !== 400) begin n_bad++; $display("FAIL trunc_hrst_gap got=%0d exp=400", c + 1); end
    n_cmp++; if ({tx_hrst, tx_hrst_flag, transmit_en} !== 3'b110) begin
      n_bad++; $display("FAIL trunc_hrst_arm got=%b exp=110", {tx_hrst, tx_hrst_flag, transmit_en}); end
    bmc_en = 1'b1;
    repeat (10) tick();
    pulse_hrst();
    n_cmp++; if (hrst_disc !== 1'b1) begin n_bad++; $display("FAIL hrst_dup_disc got=%b exp=1", hrst_disc); end
    bmc_en = 1'b0;
    tick();
    n_cmp++; if ({tx_hrst, hrst_sent} !== 2'b00) begin n_bad++; $display("FAIL hrst_drop got=%b exp=00", {tx_hrst, hrst_sent}); end
    tick();
    n_cmp++; if ({hrst_sent, msg_sent} !== 2'b10) begin n_bad++; $display("FAIL hrst_sent got=%b exp=10", {hrst_sent, msg_sent}); end
    tick();
  endtask

  task automatic test_hrst_gap_rx();
    int c;
    logic seen;
    pulse_hrst();
    repeat (201) tick();
    rx_idle = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      tick();
      seen = seen | msg_disc | hrst_disc | tx_hrst;
    end
    n_cmp++; if ({seen, sched_busy} !== 2'b01) begin n_bad++; $display("FAIL hrst_gap_no_disc got=%b exp=01", {seen, sched_busy}); end
    rx_idle = 1'b1;
    wait_hrst(c);
    n_cmp++; if (c !== 400) begin n_bad++; $display("FAIL hrst_gap_restart got=%0d exp=400", c); end
    complete_job();
    n_cmp++; if (hrst_sent !== 1'b1) begin n_bad++; $display("FAIL hrst_gap_sent got=%b exp=1", hrst_sent); end
    tick();
  endtask

  task automatic test_timeout();
    int c;
    pulse_send(2'b10);
    wait_te(c);
    n_cmp++; if ({bist_req, tx_crst_flag} !== 2'b10) begin n_bad++; $display("FAIL bist_flags got=%b exp=10", {bist_req, tx_crst_flag}); end
    c = 0;
    while (transmit_en === 1'b1 && c < 1100) begin
      tick();
      c++;
    end
    n_cmp++; if (c !== 1023) begin n_bad++; $display("FAIL launch_timeout got=%0d exp=1023", c); end
    n_cmp++; if ({tx_err, msg_disc, bist_req, tx_hrst} !== 4'b1000) begin
      n_bad++; $display("FAIL timeout_outs got=%b exp=1000", {tx_err, msg_disc, bist_req, tx_hrst}); end
    tick();
    n_cmp++; if ({tx_err, sched_busy} !== 2'b00) begin n_bad++; $display("FAIL timeout_after got=%b exp=00", {tx_err, sched_busy}); end
  endtask

  task automatic test_gap_preempt();
    int c;
    pulse_send(2'b00);
    repeat (50) tick();
    pulse_hrst();
    n_cmp++; if (msg_disc !== 1'b0) begin n_bad++; $display("FAIL preempt_early got=%b exp=0", msg_disc); end
    tick();
    n_cmp++; if (msg_disc !== 1'b1) begin n_bad++; $display("FAIL preempt_disc got=%b exp=1", msg_disc); end
    wait_hrst(c);
    n_cmp++; if (c !== 400) begin n_bad++; $display("FAIL preempt_gap got=%0d exp=400", c); end
    n_cmp++; if ({transmit_en, tx_hrst_flag} !== 2'b01) begin n_bad++; $display("FAIL preempt_job got=%b exp=01", {transmit_en, tx_hrst_flag}); end
    complete_job();
    n_cmp++; if ({hrst_sent, msg_sent} !== 2'b10) begin n_bad++; $display("FAIL preempt_sent got=%b exp=10", {hrst_sent, msg_sent}); end
    tick();
  endtask

  task automatic test_simultaneous();
    int c;
    tx_mode = 2'b00;
    txsend  = 1'b1;
    txhrst  = 1'b1;
    tick();
    txsend  = 1'b0;
    txhrst  = 1'b0;
    n_cmp++; if ({sched_busy, msg_disc, hrst_disc} !== 3'b100) begin
      n_bad++; $display("FAIL both_capture got=%b exp=100", {sched_busy, msg_disc, hrst_disc}); end
    tick();
    n_cmp++; if (msg_disc !== 1'b1) begin n_bad++; $display("FAIL both_msg_disc got=%b exp=1", msg_disc); end
    wait_hrst(c);
    n_cmp++; if (c !== 400) begin n_bad++; $display("FAIL both_hrst_gap got=%0d exp=400", c); end
    complete_job();
    n_cmp++; if ({hrst_sent, sched_busy} !== 2'b10) begin n_bad++; $display("FAIL both_sent got=%b exp=10", {hrst_sent, sched_busy}); end
    tick();
  endtask

  task automatic test_reset_abort();
    int c;
    logic [10:0] seen;
    pulse_send(2'b00);
    wait_te(c);
    bmc_en = 1'b1;
    repeat (5) tick();
    #2 ic_rst = 1'b1;
    #1;
    n_cmp++; if (outs !== 11'b0) begin n_bad++; $display("FAIL rst_async_clear got=%b exp=0", outs); end
    bmc_en = 1'b0;
    tick();
    ic_rst = 1'b0;
    seen = '0;
    repeat (5) begin
      tick();
      seen = seen | outs;
    end
    n_cmp++; if (seen !== 11'b0) begin n_bad++; $display("FAIL rst_quiet got=%b exp=0", seen); end
    pulse_send(2'b00);
    wait_te(c);
    n_cmp++; if (c !== 401) begin n_bad++; $display("FAIL rst_fresh_latency got=%0d exp=401", c); end
    complete_job();
    n_cmp++; if (msg_sent !== 1'b1) begin n_bad++; $display("FAIL rst_fresh_sent got=%b exp=1", msg_sent); end
    tick();
  endtask

  task automatic test_ucpden_abort();
    int c;
    logic [10:0] seen;
    pulse_send(2'b00);
    repeat (100) tick();
    ucpden = 1'b0;
    tick();
    n_cmp++; if (outs !== 11'b0) begin n_bad++; $display("FAIL ucpden_clear got=%b exp=0", outs); end
    seen = '0;
    repeat (5) begin
      tick();
      seen = seen | outs;
    end
    n_cmp++; if (seen !== 11'b0) begin n_bad++; $display("FAIL ucpden_quiet got=%b exp=0", seen); end
    ucpden = 1'b1;
    pulse_send(2'b00);
    wait_te(c);
    n_cmp++; if (c !== 401) begin n_bad++; $display("FAIL ucpden_fresh_latency got=%0d exp=401", c); end
    complete_job();
    n_cmp++; if (msg_sent !== 1'b1) begin n_bad++; $display("FAIL ucpden_fresh_sent got=%b exp=1", msg_sent); end
    tick();
  endtask

  initial begin
    test_reset();
    test_msg_basic();
    test_rx_busy();
    test_truncate();
    test_hrst_gap_rx();
    test_timeout();
    test_gap_preempt();
    test_simultaneous();
    test_reset_abort();
    test_ucpden_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
